regfile_mp_scoreboard: RTL

Parametrised multi-port register file, next generation of the team's combinational-read register file. Adds synchronous reset, registered reads with write-through bypass, and deterministic write-port priority. Adds a per-entry busy scoreboard (reserve/release) so issue logic can detect pending writes. Sits between decode/issue and the execution write-back ports.

---
 rtl/regfile_mp_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file: registered reads with write-through bypass, highest-port-wins writes,
// and a per-entry busy scoreboard. Build macro ZERO_REG_EN makes entry 0 a hardwired zero.
module regfile_mp_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 3,
    parameter int NUM_WRITE = 2,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WRITE-1:0]       write_en,
    input  logic [NUM_WRITE*AW-1:0]    addr_write,
    input  logic [NUM_WRITE*WIDTH-1:0] data_in,
    input  logic [NUM_READ-1:0]        read_en,
    input  logic [NUM_READ*AW-1:0]     addr_read,
    output logic [NUM_READ*WIDTH-1:0]  data_out,
    output logic [NUM_READ-1:0]        rd_valid,
    output logic [NUM_READ-1:0]        rd_busy,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    output logic [DEPTH-1:0]           busy_vec
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [DEPTH-1:0]          r_busy;
    logic [NUM_READ*WIDTH-1:0] r_data_out;
    logic [NUM_READ-1:0]       r_rd_valid;
    logic [NUM_READ-1:0]       r_rd_busy;

    logic [AW-1:0]             w_wr_addr [NUM_WRITE];
    logic [WIDTH-1:0]          w_wr_data [NUM_WRITE];
    logic [NUM_WRITE-1:0]      w_wr_ok;
    logic [AW-1:0]             w_rd_addr [NUM_READ];
    logic [WIDTH-1:0]          w_rd_data [NUM_READ];
    logic [NUM_READ-1:0]       w_rd_busy;
    logic                      w_rsv_ok;

    // An address is "live" when it maps to a real, writable entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic ok;
        ok = ({1'b0, a} < DEPTH_W);
`ifdef ZERO_REG_EN
        ok = ok && (a != '0);
`endif
        return ok;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_WRITE; k++) begin
            w_wr_addr[k] = addr_write[k*AW +: AW];
            w_wr_data[k] = data_in[k*WIDTH +: WIDTH];
            w_wr_ok[k]   = write_en[k] && addr_live(addr_write[k*AW +: AW]);
        end
        w_rsv_ok = rsv_en && addr_live(rsv_addr);
    end

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            w_rd_addr[i] = addr_read[i*AW +: AW];
        end
    end

    // Read select: ascending port scan so the highest matching write port supplies bypass data.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            w_rd_data[i] = '0;
            w_rd_busy[i] = 1'b0;
            if (addr_live(w_rd_addr[i])) begin
                w_rd_data[i] = r_mem[w_rd_addr[i]];
                w_rd_busy[i] = r_busy[w_rd_addr[i]];
            end
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (w_wr_ok[k] && (w_wr_addr[k] == w_rd_addr[i])) begin
                    w_rd_data[i] = w_wr_data[k];
                    w_rd_busy[i] = 1'b0;
                end
            end
        end
    end

    // Later non-blocking assignments override earlier ones: highest write port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                r_mem[n] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (w_wr_ok[k]) begin
                    r_mem[w_wr_addr[k]] <= w_wr_data[k];
                end
            end
        end
    end

    // Reservation is applied after write clears so it wins on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (w_wr_ok[k]) begin
                    r_busy[w_wr_addr[k]] <= 1'b0;
                end
            end
            if (w_rsv_ok) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= '0;
            r_rd_busy  <= '0;
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                r_rd_valid[i] <= read_en[i];
                if (read_en[i]) begin
                    r_data_out[i*WIDTH +: WIDTH] <= w_rd_data[i];
                    r_rd_busy[i]                 <= w_rd_busy[i];
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign rd_busy  = r_rd_busy;
    assign busy_vec = r_busy;

endmodule
